rs_bank: RTL

Parametrised multi-entry reservation station for the P6-style out-of-order core. It replaces the single-entry RS with an array of `RS_DEPTH` entries and accepts one dispatched instruction per cycle from ID/map-table/ROB. Entries wake up on CDB broadcasts, and one ready instruction per cycle is selected for issue to the functional units under a valid/grant handshake. The block sits between dispatch and the issue stage.

---
 rtl/rs_bank_pkg.sv | 58 +++++
 rtl/rs_issue_select.sv | 34 +++
 rtl/rs_bank.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/rs_bank_pkg.sv
// Shared types and constants for the multi-entry reservation station (rs_bank).
// Instruction, tag and operand widths here must match the rs_bank TAG_W / XLEN parameters.
package rs_bank_pkg;

  localparam int RS_DEPTH_DEF = 8;
  localparam int RS_TAG_W     = 5;
  localparam int RS_XLEN      = 32;
  localparam int RS_INST_W    = 32;
  // Age field is wide enough for any depth up to 256 entries.
  localparam int RS_AGE_W     = 8;

  localparam logic [RS_TAG_W-1:0] TAG_NONE = '0;

  typedef struct packed {
    logic [RS_INST_W-1:0] inst;
    logic [RS_XLEN-1:0]   rs1_value;
    logic [RS_XLEN-1:0]   rs2_value;
  } ID_PACKET;

  typedef struct packed {
    logic [RS_TAG_W-1:0] rs1_tag;
    logic [RS_TAG_W-1:0] rs2_tag;
    logic                rs1_ready;
    logic                rs2_ready;
  } MT2RS_PACKET;

  typedef struct packed {
    logic [RS_TAG_W-1:0] rob_entry;
    logic [RS_XLEN-1:0]  rs1_value;
    logic [RS_XLEN-1:0]  rs2_value;
  } ROB2RS_PACKET;

  typedef struct packed {
    logic [RS_TAG_W-1:0] reg_tag;
    logic [RS_XLEN-1:0]  reg_value;
  } CDB_PACKET;

  typedef struct packed {
    logic [RS_INST_W-1:0] inst;
    logic [RS_XLEN-1:0]   rs1_value;
    logic [RS_XLEN-1:0]   rs2_value;
    logic [RS_TAG_W-1:0]  dest_tag;
  } IS_PACKET;

  typedef struct packed {
    logic                 busy;
    logic [RS_TAG_W-1:0]  t1;
    logic [RS_TAG_W-1:0]  t2;
    logic [RS_XLEN-1:0]   v1;
    logic [RS_XLEN-1:0]   v2;
    logic                 r1;
    logic                 r2;
    logic [RS_AGE_W-1:0]  age;
    logic [RS_INST_W-1:0] inst;
    logic [RS_TAG_W-1:0]  dest;
  } RS_ENTRY_T;

endpackage

// File: rtl/rs_issue_select.sv
// Issue picker: among ready entries choose the largest age, ties to the lowest index.
// With all ages equal this degenerates to a plain lowest-index priority pick.
module rs_issue_select #(
  parameter int N  = 8,
  parameter int AW = 8
) (
  input  logic [N-1:0]         ready,
  input  logic [N-1:0][AW-1:0] age,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int IW = $clog2(N);

  logic [AW-1:0] best_age;

  always_comb begin
    grant    = '0;
    idx      = '0;
    any      = 1'b0;
    best_age = '0;
    // Strict '>' keeps the earlier (lower) index on equal ages.
    for (int i = 0; i < N; i++) begin
      if (ready[i] && (!any || (age[i] > best_age))) begin
        any      = 1'b1;
        best_age = age[i];
        idx      = IW'(i);
      end
    end
    if (any) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/rs_bank.sv
// Multi-entry reservation station: dispatch, CDB wakeup, single issue per cycle.
// Optional oldest-first select is enabled by defining RS_AGE_SELECT_EN.
module rs_bank
  import rs_bank_pkg::*;
#(
  parameter int RS_DEPTH = RS_DEPTH_DEF,
  parameter int TAG_W    = RS_TAG_W,
  parameter int XLEN     = RS_XLEN
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          dispatch_en,
  input  ID_PACKET                      id_packet_in,
  input  MT2RS_PACKET                   mt2rs_packet_in,
  input  ROB2RS_PACKET                  rob2rs_packet_in,
  input  CDB_PACKET                     cdb_packet_in,
  input  logic                          squash,
  input  logic                          issue_grant,
  output IS_PACKET                      is_packet_out,
  output logic                          issue_valid,
  output logic                          full,
  output logic [$clog2(RS_DEPTH+1)-1:0] free_count
);

  localparam int IDX_W = $clog2(RS_DEPTH);
  localparam int CNT_W = $clog2(RS_DEPTH+1);
`ifdef RS_AGE_SELECT_EN
  localparam logic [RS_AGE_W-1:0] AGE_MAX = RS_AGE_W'((1 << IDX_W) - 1);
`endif

  RS_ENTRY_T entries   [RS_DEPTH];
  RS_ENTRY_T entries_n [RS_DEPTH];
  RS_ENTRY_T new_e;

  logic [TAG_W-1:0]                  cdb_tag;
  logic [XLEN-1:0]                   cdb_val;
  logic                              cdb_live;
  logic [RS_DEPTH-1:0]               ready;
  logic [RS_DEPTH-1:0][RS_AGE_W-1:0] ages;
  logic [RS_DEPTH-1:0]               sel_oh;
  logic [IDX_W-1:0]                  sel_idx;
  logic [IDX_W-1:0]                  alloc_idx;
  logic [CNT_W-1:0]                  busy_cnt;
  logic                              do_dispatch;

  assign cdb_tag     = cdb_packet_in.reg_tag;
  assign cdb_val     = cdb_packet_in.reg_value;
  assign cdb_live    = (cdb_tag != TAG_NONE);
  assign do_dispatch = dispatch_en && !full;

  always_comb begin
    busy_cnt  = '0;
    alloc_idx = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      ready[i] = entries[i].busy && entries[i].r1 && entries[i].r2;
      ages[i]  = entries[i].age;
      busy_cnt = busy_cnt + CNT_W'(entries[i].busy);
      if (!entries[i].busy) alloc_idx = IDX_W'(i);
    end
  end

  assign free_count = CNT_W'(RS_DEPTH) - busy_cnt;
  assign full       = (free_count == '0);

  rs_issue_select #(
    .N  (RS_DEPTH),
    .AW (RS_AGE_W)
  ) u_select (
    .ready (ready),
    .age   (ages),
    .grant (sel_oh),
    .idx   (sel_idx),
    .any   (issue_valid)
  );

  // Operand capture at dispatch: ID value for no tag, ROB value if already
  // produced, otherwise wait on the tag (a same-cycle CDB match is taken now).
  always_comb begin
    new_e      = '0;
    new_e.busy = 1'b1;
    new_e.inst = id_packet_in.inst;
    new_e.dest = rob2rs_packet_in.rob_entry;
    new_e.t1   = mt2rs_packet_in.rs1_tag;
    new_e.t2   = mt2rs_packet_in.rs2_tag;
    if (mt2rs_packet_in.rs1_tag == TAG_NONE) begin
      new_e.v1 = id_packet_in.rs1_value;
      new_e.r1 = 1'b1;
    end else if (mt2rs_packet_in.rs1_ready) begin
      new_e.v1 = rob2rs_packet_in.rs1_value;
      new_e.r1 = 1'b1;
    end else if (cdb_live && (cdb_tag == mt2rs_packet_in.rs1_tag)) begin
      new_e.v1 = cdb_val;
      new_e.r1 = 1'b1;
    end
    if (mt2rs_packet_in.rs2_tag == TAG_NONE) begin
      new_e.v2 = id_packet_in.rs2_value;
      new_e.r2 = 1'b1;
    end else if (mt2rs_packet_in.rs2_ready) begin
      new_e.v2 = rob2rs_packet_in.rs2_value;
      new_e.r2 = 1'b1;
    end else if (cdb_live && (cdb_tag == mt2rs_packet_in.rs2_tag)) begin
      new_e.v2 = cdb_val;
      new_e.r2 = 1'b1;
    end
  end

  // Handshake: is_packet_out is presented while issue_valid is high; the
  // selected entry leaves at the edge where issue_valid && issue_grant.
  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      entries_n[i] = entries[i];
      if (entries[i].busy && !entries[i].r1 && cdb_live && (entries[i].t1 == cdb_tag)) begin
        entries_n[i].v1 = cdb_val;
        entries_n[i].r1 = 1'b1;
      end
      if (entries[i].busy && !entries[i].r2 && cdb_live && (entries[i].t2 == cdb_tag)) begin
        entries_n[i].v2 = cdb_val;
        entries_n[i].r2 = 1'b1;
      end
`ifdef RS_AGE_SELECT_EN
      if (do_dispatch && entries[i].busy && (entries[i].age != AGE_MAX))
        entries_n[i].age = entries[i].age + 1'b1;
`endif
      if (issue_grant && sel_oh[i]) entries_n[i].busy = 1'b0;
    end
    if (do_dispatch) entries_n[alloc_idx] = new_e;
    if (squash) begin
      for (int i = 0; i < RS_DEPTH; i++) entries_n[i].busy = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RS_DEPTH; i++) entries[i] <= '0;
    end else begin
      for (int i = 0; i < RS_DEPTH; i++) entries[i] <= entries_n[i];
    end
  end

  always_comb begin
    is_packet_out = '0;
    if (issue_valid) begin
      is_packet_out.inst      = entries[sel_idx].inst;
      is_packet_out.rs1_value = entries[sel_idx].v1;
      is_packet_out.rs2_value = entries[sel_idx].v2;
      is_packet_out.dest_tag  = entries[sel_idx].dest;
    end
  end

endmodule
